// File: rtl/regfile_write_ctrl.sv
// Write side of the 16-entry register file: owns r0..r15 and runs a 16-cycle clear sweep to CLR_VALUE.
// Latency: a write is visible on rN the cycle after the accepting edge; clr_done pulses the cycle after the 16th sweep edge.
// Backpressure: wr_ready is low for the whole sweep, and writes offered then are dropped, not queued.
// Optional macro REG0_ZERO_EN makes r0 read as zero; writes to address 0 are then accepted and discarded.
module regfile_write_ctrl #(
    parameter int              WIDTH     = 16,
    parameter logic [WIDTH-1:0] CLR_VALUE = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_valid,
    input  logic [3:0]       wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    output logic             wr_ready,
    input  logic             clr_req,
    output logic             busy,
    output logic             clr_done,
    output logic [WIDTH-1:0] r0,
    output logic [WIDTH-1:0] r1,
    output logic [WIDTH-1:0] r2,
    output logic [WIDTH-1:0] r3,
    output logic [WIDTH-1:0] r4,
    output logic [WIDTH-1:0] r5,
    output logic [WIDTH-1:0] r6,
    output logic [WIDTH-1:0] r7,
    output logic [WIDTH-1:0] r8,
    output logic [WIDTH-1:0] r9,
    output logic [WIDTH-1:0] r10,
    output logic [WIDTH-1:0] r11,
    output logic [WIDTH-1:0] r12,
    output logic [WIDTH-1:0] r13,
    output logic [WIDTH-1:0] r14,
    output logic [WIDTH-1:0] r15
);

    typedef enum logic {IDLE, CLEAR} state_t;

`ifdef REG0_ZERO_EN
    // r0 keeps real storage but every load path feeds it zero, so it reads as a constant.
    localparam logic [WIDTH-1:0] R0_CLR = {WIDTH{1'b0}};
    localparam bit               WR0_EN = 1'b0;
`else
    localparam logic [WIDTH-1:0] R0_CLR = CLR_VALUE;
    localparam bit               WR0_EN = 1'b1;
`endif

    state_t           state;
    logic [3:0]       cnt;
    logic [WIDTH-1:0] regs [16];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) begin
                regs[i] <= (i == 0) ? R0_CLR : CLR_VALUE;
            end
            state    <= IDLE;
            cnt      <= 4'd0;
            wr_ready <= 1'b1;
            busy     <= 1'b0;
            clr_done <= 1'b0;
        end else begin
            clr_done <= 1'b0;
            case (state)
                IDLE: begin
                    // A write and a clear request on the same edge both take effect.
                    if (wr_valid && (WR0_EN || wr_addr != 4'd0)) begin
                        regs[wr_addr] <= wr_data;
                    end
                    if (clr_req) begin
                        state    <= CLEAR;
                        cnt      <= 4'd0;
                        wr_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                CLEAR: begin
                    regs[cnt] <= (cnt == 4'd0) ? R0_CLR : CLR_VALUE;
                    cnt       <= cnt + 4'd1;
                    if (cnt == 4'd15) begin
                        state    <= IDLE;
                        wr_ready <= 1'b1;
                        busy     <= 1'b0;
                        clr_done <= 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    wr_ready <= 1'b1;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

    assign r0  = regs[0];
    assign r1  = regs[1];
    assign r2  = regs[2];
    assign r3  = regs[3];
    assign r4  = regs[4];
    assign r5  = regs[5];
    assign r6  = regs[6];
    assign r7  = regs[7];
    assign r8  = regs[8];
    assign r9  = regs[9];
    assign r10 = regs[10];
    assign r11 = regs[11];
    assign r12 = regs[12];
    assign r13 = regs[13];
    assign r14 = regs[14];
    assign r15 = regs[15];

endmodule

// File: tb/tb_regfile_write_ctrl.sv
// Scoreboarded bench for regfile_write_ctrl: directed scenarios followed by random traffic.
module tb_regfile_write_ctrl;

    localparam int W = 16;
    localparam logic [W-1:0] CLRV = 16'h0000;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic wr_valid = 1'b0;
    logic [3:0] wr_addr = 4'd0;
    logic [W-1:0] wr_data = '0;
    logic clr_req = 1'b0;
    logic wr_ready, busy, clr_done;
    logic [W-1:0] r0, r1, r2, r3, r4, r5, r6, r7, r8, r9, r10, r11, r12, r13, r14, r15;
    logic [15:0][W-1:0] dut_r;

    regfile_write_ctrl #(.WIDTH(W), .CLR_VALUE(CLRV)) dut (
        .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_ready(wr_ready), .clr_req(clr_req), .busy(busy), .clr_done(clr_done),
        .r0(r0), .r1(r1), .r2(r2), .r3(r3), .r4(r4), .r5(r5), .r6(r6), .r7(r7),
        .r8(r8), .r9(r9), .r10(r10), .r11(r11), .r12(r12), .r13(r13), .r14(r14), .r15(r15)
    );

    assign dut_r = {r15, r14, r13, r12, r11, r10, r9, r8, r7, r6, r5, r4, r3, r2, r1, r0};

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0][W-1:0] r;
        logic               rdy;
        logic               bsy;
        logic               done;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Reference model: a register array plus the position of the sweep (-1 when not sweeping).
    logic [W-1:0] m_r [16];
    int           m_pos = -1;
    logic         m_done = 1'b0;

    function automatic logic [W-1:0] clr_of(input int idx);
`ifdef REG0_ZERO_EN
        if (idx == 0) return '0;
`endif
        return CLRV;
    endfunction

    task automatic model_step(input logic rs, input logic v, input logic [3:0] a,
                              input logic [W-1:0] d, input logic c);
        if (rs) begin
            for (int i = 0; i < 16; i++) m_r[i] = clr_of(i);
            m_pos  = -1;
            m_done = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_pos < 0) begin
                if (v) begin
`ifdef REG0_ZERO_EN
                    if (a != 4'd0) m_r[a] = d;
`else
                    m_r[a] = d;
`endif
                end
                if (c) m_pos = 0;
            end else begin
                m_r[m_pos] = clr_of(m_pos);
                m_pos = m_pos + 1;
                if (m_pos == 16) begin
                    m_pos  = -1;
                    m_done = 1'b1;
                end
            end
        end
    endtask

    task automatic drive(input logic rs, input logic v, input logic [3:0] a,
                         input logic [W-1:0] d, input logic c);
        exp_t e;
        @(negedge clk);
        reset    = rs;
        wr_valid = v;
        wr_addr  = a;
        wr_data  = d;
        clr_req  = c;
        model_step(rs, v, a, d, c);
        for (int i = 0; i < 16; i++) e.r[i] = m_r[i];
        e.rdy  = (m_pos < 0);
        e.bsy  = (m_pos >= 0);
        e.done = m_done;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 4'd0, '0, 1'b0);
    endtask

    // Monitor: every cycle the DUT presents a full register/status snapshot.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                vectors++;
                for (int i = 0; i < 16; i++) begin
                    if (dut_r[i] !== e.r[i]) begin
                        miscompares++;
                        $display("FAIL r%0d at %0t: got %h expected %h", i, $time, dut_r[i], e.r[i]);
                    end
                end
                if (wr_ready !== e.rdy) begin
                    miscompares++;
                    $display("FAIL wr_ready at %0t: got %b expected %b", $time, wr_ready, e.rdy);
                end
                if (busy !== e.bsy) begin
                    miscompares++;
                    $display("FAIL busy at %0t: got %b expected %b", $time, busy, e.bsy);
                end
                if (clr_done !== e.done) begin
                    miscompares++;
                    $display("FAIL clr_done at %0t: got %b expected %b", $time, clr_done, e.done);
                end
            end
        end
    end

    initial begin
        drive(1'b1, 1'b0, 4'd0, '0, 1'b0);
        drive(1'b1, 1'b0, 4'd0, '0, 1'b0);
        idle(2);
        // Back-to-back writes to different registers.
        drive(1'b0, 1'b1, 4'h3, 16'hBEEF, 1'b0);
        drive(1'b0, 1'b1, 4'hF, 16'h1234, 1'b0);
        idle(1);
        // Same address twice in a row: last write wins.
        drive(1'b0, 1'b1, 4'h7, 16'h1111, 1'b0);
        drive(1'b0, 1'b1, 4'h7, 16'h2222, 1'b0);
        // Fill, then a one-cycle clear pulse and the full sweep.
        for (int n = 0; n < 16; n++) drive(1'b0, 1'b1, n[3:0], 16'h1000 + 16'(n), 1'b0);
        drive(1'b0, 1'b0, 4'd0, '0, 1'b1);
        idle(19);
        // Refill, start a sweep, offer a write mid-sweep, then abort it with reset.
        for (int n = 0; n < 16; n++) drive(1'b0, 1'b1, n[3:0], 16'h2000 + 16'(n), 1'b0);
        drive(1'b0, 1'b0, 4'd0, '0, 1'b1);
        idle(8);
        drive(1'b0, 1'b1, 4'd2, 16'hAAAA, 1'b0);
        drive(1'b0, 1'b1, 4'd2, 16'hAAAA, 1'b0);
        drive(1'b1, 1'b0, 4'd0, '0, 1'b0);
        idle(20);
        // Simultaneous write and clear request.
        drive(1'b0, 1'b1, 4'd5, 16'h5555, 1'b1);
        idle(18);
        // Address 0 write (discarded when r0 is hardwired).
        drive(1'b0, 1'b1, 4'd0, 16'hFFFF, 1'b0);
        idle(2);
        // clr_req held high across sweeps: ignored mid-sweep, restarts on re-entering idle.
        for (int n = 0; n < 40; n++) drive(1'b0, 1'b1, 4'd9, 16'h9999, 1'b1);
        idle(20);
        // Random traffic.
        for (int n = 0; n < 2000; n++) begin
            drive(($urandom_range(0, 99) == 0), $urandom_range(0, 1) == 1,
                  4'($urandom_range(0, 15)), 16'($urandom),
                  ($urandom_range(0, 19) == 0));
        end
        idle(2);
        @(negedge clk);
        @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected snapshots left unchecked, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
